seq_mult_ctrl: RTL and testbench

Control FSM for the shift-add sequential multiplier datapath (A/B/P registers with load/shift and load/add selects). It turns a four-phase `go`/`done` handshake into the per-cycle enable and select strobes: load the operands, then one shift-add iteration per cycle until B is exhausted. It terminates early when B reaches zero, with an iteration-count cap as a safeguard. It sits beside the datapath inside the multiplier top level; the datapath returns `zero` (B == 0) and `lsb_b` (B[0]).

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_iter_cnt.sv | 31 +++
 rtl/seq_mult_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_mult_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-add sequential multiplier: controller
// state encoding and the register select values the datapath decodes.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A/B select: parallel load vs shift (A left, B right).
    localparam logic SEL_LOAD  = 1'b1;
    localparam logic SEL_SHIFT = 1'b0;

    // P select: clear to zero vs accumulate P + A.
    localparam logic SEL_CLEAR = 1'b1;
    localparam logic SEL_ADD   = 1'b0;

endpackage

// File: rtl/seq_mult_iter_cnt.sv
// Saturating iteration counter: synchronous clear, increment that stops at
// WIDTH, never wraps. Flags when the cap has been reached.
module seq_mult_iter_cnt #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(WIDTH);

    assign at_max = (count == MAX_COUNT);

    // Count register: clear wins over increment; increment holds at the cap.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add multiplier. Converts the four-phase go/done
// handshake into per-cycle register enables and selects: one LOAD cycle,
// then one shift-add per RUN cycle until B is zero or WIDTH iterations ran.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             go,
    input  logic             abort,
    input  logic             zero,
    input  logic             lsb_b,
    output logic             en_a,
    output logic             en_b,
    output logic             en_p,
    output logic             ld_shift_a,
    output logic             ld_shift_b,
    output logic             ld_add_p,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    state_t state;
    state_t next_state;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   at_max;
    logic   run_exit;

    // RUN ends when B is exhausted or the iteration cap is hit (either or both).
    assign run_exit = zero || at_max;

    seq_mult_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .count  (iter),
        .at_max (at_max)
    );

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every transition, including go in IDLE.
    // NOTE: next_state is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (go)       next_state = ST_LOAD;
            ST_LOAD:               next_state = ST_RUN;
            ST_RUN:  if (run_exit) next_state = ST_DONE;
            ST_DONE: if (!go)      next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
        if (abort) begin
            next_state = ST_IDLE;
        end
    end

    // Output strobes: Moore on state, except en_p in RUN follows lsb_b.
    // Abort gates all enables in the cycle it is seen.
    always_comb begin
        en_a       = 1'b0;
        en_b       = 1'b0;
        en_p       = 1'b0;
        ld_shift_a = SEL_SHIFT;
        ld_shift_b = SEL_SHIFT;
        ld_add_p   = SEL_ADD;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        unique case (state)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                busy      = 1'b1;
                cnt_clear = 1'b1;
                if (!abort) begin
                    en_a       = 1'b1;
                    en_b       = 1'b1;
                    en_p       = 1'b1;
                    ld_shift_a = SEL_LOAD;
                    ld_shift_b = SEL_LOAD;
                    ld_add_p   = SEL_CLEAR;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!abort && !run_exit) begin
                    en_a       = 1'b1;
                    en_b       = 1'b1;
                    en_p       = lsb_b;
                    ld_shift_a = SEL_SHIFT;
                    ld_shift_b = SEL_SHIFT;
                    ld_add_p   = SEL_ADD;
                    cnt_inc    = 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl. A small behavioural datapath
// (A/B/P registers) is driven by the controller strobes and feeds back
// zero/lsb_b. Expected products and iteration counts go into a scoreboard
// when go is driven and are compared when done rises.
module tb_seq_mult_ctrl;
    import seq_mult_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk   = 1'b0;
    logic             clr_n = 1'b0;
    logic             go    = 1'b0;
    logic             abort = 1'b0;
    logic             zero;
    logic             lsb_b;
    logic             en_a, en_b, en_p;
    logic             ld_shift_a, ld_shift_b, ld_add_p;
    logic             busy, done;
    logic [CNT_W-1:0] iter;

    seq_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .go         (go),
        .abort      (abort),
        .zero       (zero),
        .lsb_b      (lsb_b),
        .en_a       (en_a),
        .en_b       (en_b),
        .en_p       (en_p),
        .ld_shift_a (ld_shift_a),
        .ld_shift_b (ld_shift_b),
        .ld_add_p   (ld_add_p),
        .busy       (busy),
        .done       (done),
        .iter       (iter)
    );

    always #5 clk = ~clk;

    // Behavioural datapath
    logic [WIDTH-1:0]   a_in  = '0;
    logic [WIDTH-1:0]   b_in  = '0;
    logic [2*WIDTH-1:0] reg_a = '0;
    logic [WIDTH-1:0]   reg_b = '0;
    logic [2*WIDTH-1:0] reg_p = '0;

    always @(posedge clk) begin
        if (en_a) reg_a <= (ld_shift_a == SEL_LOAD)  ? {{WIDTH{1'b0}}, a_in} : reg_a << 1;
        if (en_b) reg_b <= (ld_shift_b == SEL_LOAD)  ? b_in : reg_b >> 1;
        if (en_p) reg_p <= (ld_add_p   == SEL_CLEAR) ? '0   : reg_p + reg_a;
    end

    assign zero  = (reg_b == '0);
    assign lsb_b = reg_b[0];

    // Scoreboard
    typedef struct {
        logic [2*WIDTH-1:0] p;
        int                 n_iter;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int msb_k(input logic [WIDTH-1:0] b);
        int k = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // One full operation with go held through DONE for `hold` extra cycles.
    task automatic run_op(input int a, input int b, input int hold);
        exp_t             e;
        exp_t             got_e;
        logic [WIDTH-1:0] bb;
        int               k;
        int               cyc;
        int               r;
        bit               seen;

        bb       = WIDTH'(b);
        k        = msb_k(bb);
        e.p      = (2*WIDTH)'(a * b);
        e.n_iter = k;
        sb.push_back(e);

        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        a_in = WIDTH'(a);
        b_in = bb;
        go   = 1'b1;

        step();
        check("load_strobes",
              32'({en_a, en_b, en_p, ld_shift_a, ld_shift_b, ld_add_p, busy, done}),
              32'b1111_1110);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < WIDTH + 6) begin
            step();
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                r = cyc - 2;
                if (r < k)
                    check("run_shift",
                          32'({en_a, en_b, en_p, ld_shift_a, ld_shift_b, ld_add_p, busy}),
                          32'({1'b1, 1'b1, bb[r], 3'b000, 1'b1}));
                else
                    check("run_exit",
                          32'({en_a, en_b, en_p, ld_shift_a, ld_shift_b, ld_add_p, busy}),
                          32'b000_0001);
                check("run_iter", 32'(iter), 32'(r > WIDTH ? WIDTH : r));
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) check("latency", 32'(cyc - 1), 32'(k + 2));

        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            if (seen) begin
                check("p_out", 32'(reg_p), 32'(got_e.p));
                check("iter_done", 32'(iter), 32'(got_e.n_iter));
                check("done_busy", 32'({busy, en_a, en_b, en_p}), 32'd0);
            end
        end

        for (int i = 0; i < hold; i++) begin
            step();
            check("done_hold", 32'({done, busy}), 32'b10);
            check("done_hold_p", 32'(reg_p), 32'(e.p));
        end

        go = 1'b0;
        step();
        check("back_idle", 32'({done, busy, en_a, en_b, en_p}), 32'd0);
        check("iter_kept", 32'(iter), 32'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_outputs",
              32'({en_a, en_b, en_p, ld_shift_a, ld_shift_b, ld_add_p, busy, done}), 32'd0);
        check("rst_iter", 32'(iter), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        step();

        run_op(2, 3, 0);
        run_op(5, 0, 0);
        run_op(15, 15, 5);
        run_op(3, 10, 0);

        // Abort during the second RUN cycle
        a_in = 4'd7;
        b_in = 4'd12;
        go   = 1'b1;
        step();           // LOAD
        step();           // RUN, first iteration
        step();           // RUN, second iteration
        check("abort_pre", 32'({en_a, en_b, busy}), 32'b111);
        abort = 1'b1;
        go    = 1'b0;
        #1;
        check("abort_enables", 32'({en_a, en_b, en_p}), 32'd0);
        step();
        abort = 1'b0;
        check("abort_idle", 32'({busy, done}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", 32'({busy, done}), 32'd0);
        end

        // go together with abort in IDLE is not accepted
        abort = 1'b1;
        go    = 1'b1;
        step();
        check("abort_blocks_go", 32'({busy, en_a}), 32'd0);
        abort = 1'b0;
        go    = 1'b0;
        step();
        check("idle_after_block", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        a_in = 4'd2;
        b_in = 4'd3;
        go   = 1'b1;
        step();           // LOAD
        step();           // RUN, iter 0
        step();           // RUN, iter 1
        check("pre_rst_iter", 32'(iter), 32'd1);
        #2;
        clr_n = 1'b0;
        go    = 1'b0;
        #1;
        check("async_rst_outputs",
              32'({en_a, en_b, en_p, ld_shift_a, ld_shift_b, ld_add_p, busy, done}), 32'd0);
        check("async_rst_iter", 32'(iter), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        step();

        run_op(2, 3, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
